// File: rtl/loop_nest_controller.sv
// -----------------------------------------------------------------------------
// loop_nest_controller
//
// Nested-loop iteration controller for the systolic-array instruction path.
// The instruction decoder writes per-group loop bounds (outermost level first).
// On start, the controller walks the active group's loop nest one index tuple
// at a time. Tuples are offered to the address generators over a valid/ready
// handshake. When the active group id changes mid-walk, the running group's
// iterators are saved into its context slot. The new group then resumes from
// its own saved context.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   cfg_loop_iter_v    config write strobe
//   cfg_loop_iter      last index (trip count - 1) of the next loop level
//   cfg_loop_group_id  group targeted by the config write
//   cfg_clear          clears all config, contexts and the overflow flag
//   start              start the active group from index 0 (acted on in IDLE)
//   loop_group_id      active group
//   iter_ready         consumer accepts the current tuple
//   iter_v             current_iters is valid
//   current_iters      index tuple, loop l at [l*LOOP_ITER_W +: LOOP_ITER_W]
//   iter_last          bit l: loops l..NUM_LOOPS-1 all at max; top bit is 1
//   busy               controller is not idle
//   done               one-cycle pulse when the nest completes
//   cfg_err            sticky flag: a config write found its group full
// -----------------------------------------------------------------------------
module loop_nest_controller #(
   parameter int LOOP_ID_W   = 3,
   parameter int GROUP_ID_W  = 2,
   parameter int LOOP_ITER_W = 16,
   parameter int NUM_LOOPS   = 1 << LOOP_ID_W,
   parameter int NUM_GROUPS  = 1 << GROUP_ID_W
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             cfg_loop_iter_v,
   input  logic [LOOP_ITER_W-1:0]           cfg_loop_iter,
   input  logic [GROUP_ID_W-1:0]            cfg_loop_group_id,
   input  logic                             cfg_clear,
   input  logic                             start,
   input  logic [GROUP_ID_W-1:0]            loop_group_id,
   input  logic                             iter_ready,
   output logic                             iter_v,
   output logic [LOOP_ITER_W*NUM_LOOPS-1:0] current_iters,
   output logic [NUM_LOOPS:0]               iter_last,
   output logic                             busy,
   output logic                             done,
   output logic                             cfg_err
);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, SWITCH, DONE} state_t;

   // The write counter needs one extra bit so that "full" (== NUM_LOOPS)
   // is distinguishable from "empty".
   localparam logic [LOOP_ID_W:0] CNT_FULL = (LOOP_ID_W+1)'(NUM_LOOPS);

   state_t state, next_state;

   logic [LOOP_ITER_W-1:0] max_cfg   [NUM_GROUPS][NUM_LOOPS];
   logic [NUM_LOOPS-1:0]   valid_cfg [NUM_GROUPS];
   logic [LOOP_ID_W:0]     cnt       [NUM_GROUPS];
   logic [LOOP_ITER_W-1:0] ctx       [NUM_GROUPS][NUM_LOOPS];

   logic [LOOP_ITER_W-1:0] work_max   [NUM_LOOPS];
   logic [LOOP_ITER_W-1:0] iters      [NUM_LOOPS];
   logic [LOOP_ITER_W-1:0] next_iters [NUM_LOOPS];

   logic [GROUP_ID_W-1:0]  grp;
   logic [GROUP_ID_W-1:0]  prev_grp;
   logic                   group_changed;
   logic                   accept;

   logic [LOOP_ID_W:0]     wr_cnt;
   logic [LOOP_ID_W-1:0]   wr_idx;
   logic                   wr_full;

   assign wr_cnt        = cnt[cfg_loop_group_id];
   assign wr_idx        = wr_cnt[LOOP_ID_W-1:0];
   assign wr_full       = (wr_cnt == CNT_FULL);
   assign group_changed = (loop_group_id != prev_grp);

   // ---------------------------------------------------------------------------
   // Configuration store. A clear beats a simultaneous write.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cfg_err <= 1'b0;
         for (int g = 0; g < NUM_GROUPS; g++) begin
            cnt[g]       <= '0;
            valid_cfg[g] <= '0;
            for (int l = 0; l < NUM_LOOPS; l++) begin
               max_cfg[g][l] <= '0;
            end
         end
      end else if (cfg_clear) begin
         cfg_err <= 1'b0;
         for (int g = 0; g < NUM_GROUPS; g++) begin
            cnt[g]       <= '0;
            valid_cfg[g] <= '0;
         end
      end else if (cfg_loop_iter_v) begin
         if (wr_full) begin
            cfg_err <= 1'b1;
         end else begin
            max_cfg[cfg_loop_group_id][wr_idx]   <= cfg_loop_iter;
            valid_cfg[cfg_loop_group_id][wr_idx] <= 1'b1;
            cnt[cfg_loop_group_id]               <= wr_cnt + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Per-group saved iterator contexts.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int g = 0; g < NUM_GROUPS; g++) begin
            for (int l = 0; l < NUM_LOOPS; l++) begin
               ctx[g][l] <= '0;
            end
         end
      end else if (cfg_clear) begin
         for (int g = 0; g < NUM_GROUPS; g++) begin
            for (int l = 0; l < NUM_LOOPS; l++) begin
               ctx[g][l] <= '0;
            end
         end
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  for (int l = 0; l < NUM_LOOPS; l++) begin
                     ctx[loop_group_id][l] <= '0;
                  end
               end
            end
            SWITCH: begin
               // Holds the already-advanced tuple if an accept coincided
               // with the group change.
               for (int l = 0; l < NUM_LOOPS; l++) begin
                  ctx[grp][l] <= iters[l];
               end
            end
            DONE: begin
               for (int l = 0; l < NUM_LOOPS; l++) begin
                  ctx[grp][l] <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Working bounds, iterators and group tracking.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grp      <= '0;
         prev_grp <= '0;
         for (int l = 0; l < NUM_LOOPS; l++) begin
            work_max[l] <= '0;
            iters[l]    <= '0;
         end
      end else begin
         prev_grp <= loop_group_id;
         case (state)
            LOAD: begin
               grp <= loop_group_id;
               for (int l = 0; l < NUM_LOOPS; l++) begin
                  // Unwritten levels run exactly once.
                  work_max[l] <= valid_cfg[loop_group_id][l] ?
                                 max_cfg[loop_group_id][l] : '0;
                  iters[l]    <= ctx[loop_group_id][l];
               end
            end
            RUN: begin
               if (accept && !iter_last[0]) begin
                  for (int l = 0; l < NUM_LOOPS; l++) begin
                     iters[l] <= next_iters[l];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Odometer: iter_last ripples from the innermost loop outward.
   // ---------------------------------------------------------------------------
   always_comb begin : last_chain
      logic acc;
      acc                  = 1'b1;
      iter_last            = '0;
      iter_last[NUM_LOOPS] = 1'b1;
      for (int l = NUM_LOOPS - 1; l >= 0; l--) begin
         acc          = acc & (iters[l] == work_max[l]);
         iter_last[l] = acc;
      end
   end

   always_comb begin
      for (int l = 0; l < NUM_LOOPS; l++) begin
         next_iters[l] = iters[l];
         if (iter_last[l]) begin
            next_iters[l] = '0;
         end else if (iter_last[l+1]) begin
            next_iters[l] = iters[l] + 1'b1;
         end
      end
   end

   always_comb begin
      current_iters = '0;
      for (int l = 0; l < NUM_LOOPS; l++) begin
         current_iters[l*LOOP_ITER_W +: LOOP_ITER_W] = iters[l];
      end
   end

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      iter_v     = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) begin
               next_state = LOAD;
            end
         end
         LOAD: begin
            next_state = RUN;
         end
         RUN: begin
            iter_v = 1'b1;
            accept = iter_ready;
            // Completion takes priority over a simultaneous group change.
            if (accept && iter_last[0]) begin
               next_state = DONE;
            end else if (group_changed) begin
               next_state = SWITCH;
            end
         end
         SWITCH: begin
            next_state = LOAD;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule
